// File: rtl/mem_probe_pkg.sv
// Shared constants and types for the memory probe: FSM encoding,
// debounce default and the autoscan interval used by MEM_PROBE_AUTOSCAN_EN.
package mem_probe_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_SHOW = 2'd3;

    localparam int DB_CNT_DEF = 32000;

    // Autoscan interval is 2^AUTOSCAN_W cycles; timer terminal count below.
    localparam int AUTOSCAN_W = 24;
    localparam logic [AUTOSCAN_W-1:0] AUTOSCAN_LAST = '1;

    typedef struct packed {
        logic nxt;
        logic prv;
    } btn_pulse_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b10
    } step_t;

    // Simultaneous pulses cancel out.
    function automatic step_t step_dir(btn_pulse_t p);
        step_t s;
        s = STEP_NONE;
        if (p.nxt && !p.prv) begin
            s = STEP_UP;
        end else if (p.prv && !p.nxt) begin
            s = STEP_DOWN;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_probe_if.sv
// Debug read port between the probe (master) and the data memory (slave).
// Read data is valid RD_LAT cycles after the mem_rd strobe.
interface mem_probe_if #(
    parameter int ADDR_W = 8
);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata
    );

endinterface

// File: rtl/mem_probe_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle pulse on each accepted rising level.
module btn_debounce
    import mem_probe_pkg::*;
#(
    parameter int DB_CNT = DB_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            pulse <= 1'b0;
            // Any sample matching the accepted level restarts the count.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= s2;
                pulse <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_probe.sv
// Button-driven data-memory viewer feeding a seven-segment driver.
// Define MEM_PROBE_AUTOSCAN_EN to auto-step the address while idle in SHOW.
module mem_probe
    import mem_probe_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DB_CNT = DB_CNT_DEF,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        sw_en,
    mem_probe_if.master bus,
    output logic [31:0] doutbM,
    output logic        memread_en
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       dout;
    logic [1:0]        wcnt;
    btn_pulse_t        pl;
    step_t             step;
    logic              any_pl;
    logic              tick;

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .pulse (pl.nxt)
    );

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_prev (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_prev),
        .pulse (pl.prv)
    );

    assign step   = step_dir(pl);
    assign any_pl = pl.nxt | pl.prv;

`ifdef MEM_PROBE_AUTOSCAN_EN
    logic [AUTOSCAN_W-1:0] tmr;

    // Interval runs only while showing; any pulse restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (state != ST_SHOW || any_pl) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 1'b1;
        end
    end

    assign tick = (state == ST_SHOW) && (tmr == AUTOSCAN_LAST) && !any_pl;
`else
    assign tick = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            addr  <= '0;
            dout  <= '0;
            wcnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state <= ST_READ;
                end
                ST_READ: begin
                    wcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wcnt == WAIT_LAST) begin
                        dout  <= bus.mem_rdata;
                        wcnt  <= '0;
                        state <= ST_SHOW;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (step == STEP_UP || tick) begin
                        addr  <= addr + 1'b1;
                        state <= ST_READ;
                    end else if (step == STEP_DOWN) begin
                        addr  <= addr - 1'b1;
                        state <= ST_READ;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr = addr;
    assign bus.mem_rd   = (state == ST_READ);
    assign doutbM       = dout;
    assign memread_en   = (state == ST_SHOW) && sw_en;

endmodule
